// File: rtl/yl3_frame_receiver.sv
// yl3_frame_receiver: deserialises YL-3 sda/sclk/slatch frames, validates them and keeps an 8-digit segment shadow.
module yl3_frame_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sda,
    input  logic        sclk,
    input  logic        slatch,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [7:0]  frame_pos,
    output logic [7:0]  frame_seg,
    output logic [2:0]  frame_idx,
    output logic        pos_err,
    output logic        len_err,
    output logic        overrun,
    output logic [63:0] disp
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sda_q;
    logic [SYNC_STAGES:0] sclk_q, slatch_q;
    logic [15:0] sr_q, sr_d;
    logic [4:0] cnt_q, cnt_d;
    logic valid_q, valid_d, perr_q, perr_d, lerr_q, lerr_d, ovr_q, ovr_d;
    logic [7:0] pos_q, pos_d, seg_q, seg_d, pos_new;
    logic [2:0] idx_q, idx_d, idx_new;
    logic [63:0] disp_q, disp_d;
    logic sclk_rise, latch_rise, pos_bad, len_bad;
    assign sclk_rise  = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign latch_rise = slatch_q[SYNC_STAGES-1] & ~slatch_q[SYNC_STAGES];
    always_comb begin
        sr_d    = sclk_rise ? {sr_q[14:0], sda_q[SYNC_STAGES-1]} : sr_q;
        cnt_d   = (sclk_rise && cnt_q != 5'd31) ? cnt_q + 5'd1 : cnt_q;
        pos_new = sr_d[15:8];
        pos_bad = $countones(pos_new) != 1;
        len_bad = cnt_d != 5'(FRAME_BITS);
        idx_new = 3'd0;
        for (int i = 0; i < 8; i++)
            if (pos_new[i]) idx_new = 3'(i);
        valid_d = valid_q & ~frame_ready;
        pos_d   = pos_q;
        seg_d   = seg_q;
        idx_d   = idx_q;
        perr_d  = perr_q;
        lerr_d  = lerr_q;
        ovr_d   = ovr_q;
        disp_d  = disp_q;
        state_d = sclk_rise ? SHIFT : state_q;
        // the shift of this cycle is folded in before the latch samples sr_d/cnt_d
        if (latch_rise) begin
            valid_d = 1'b1;
            pos_d   = pos_new;
            seg_d   = sr_d[7:0];
            idx_d   = pos_bad ? 3'd0 : idx_new;
            perr_d  = pos_bad;
            lerr_d  = len_bad;
            ovr_d   = ovr_q | (valid_q & ~frame_ready);
            cnt_d   = 5'd0;
            state_d = IDLE;
            if (!pos_bad && !len_bad)
                disp_d[{3'd7 - idx_new, 3'b000} +: 8] = sr_d[7:0];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sda_q    <= '0;
            sclk_q   <= '0;
            slatch_q <= '0;
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            pos_q    <= '0;
            seg_q    <= '0;
            idx_q    <= '0;
            perr_q   <= 1'b0;
            lerr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            disp_q   <= '1;
        end else begin
            sda_q    <= {sda_q[SYNC_STAGES-2:0], sda};
            sclk_q   <= {sclk_q[SYNC_STAGES-1:0], sclk};
            slatch_q <= {slatch_q[SYNC_STAGES-1:0], slatch};
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            pos_q    <= pos_d;
            seg_q    <= seg_d;
            idx_q    <= idx_d;
            perr_q   <= perr_d;
            lerr_q   <= lerr_d;
            ovr_q    <= ovr_d;
            disp_q   <= disp_d;
        end
    end
    assign frame_valid = valid_q;
    assign frame_pos   = pos_q;
    assign frame_seg   = seg_q;
    assign frame_idx   = idx_q;
    assign pos_err     = perr_q;
    assign len_err     = lerr_q;
    assign overrun     = ovr_q;
    assign disp        = disp_q;
endmodule

// File: tb/tb_yl3_frame_receiver.sv
// tb_yl3_frame_receiver: random and directed frames checked against a bit-stream reference model.
module tb_yl3_frame_receiver;
    localparam int H = 6;
    logic clk = 1'b0, rst_n = 1'b0, sda = 1'b0, sclk = 1'b0, slatch = 1'b0, frame_ready = 1'b0;
    logic frame_valid, pos_err, len_err, overrun;
    logic [7:0] frame_pos, frame_seg;
    logic [2:0] frame_idx;
    logic [63:0] disp;
    int n_chk = 0, n_pass = 0, vcyc = 0;
    bit stream[$];
    int m_cnt;
    logic [7:0] m_disp[8];
    logic m_valid, m_ovr, m_perr, m_lerr;
    logic [7:0] m_pos, m_seg;
    logic [2:0] m_idx;
    always #10 clk = ~clk;
    always @(negedge clk) if (frame_valid) vcyc++;
    yl3_frame_receiver dut (
        .clk(clk), .rst_n(rst_n), .sda(sda), .sclk(sclk), .slatch(slatch),
        .frame_ready(frame_ready), .frame_valid(frame_valid), .frame_pos(frame_pos),
        .frame_seg(frame_seg), .frame_idx(frame_idx), .pos_err(pos_err),
        .len_err(len_err), .overrun(overrun), .disp(disp)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic model_reset();
        stream.delete();
        m_cnt = 0;
        for (int i = 0; i < 8; i++) m_disp[i] = 8'hFF;
        {m_valid, m_ovr, m_perr, m_lerr, m_pos, m_seg, m_idx} = '0;
    endtask
    task automatic model_latch();
        logic [15:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 16; i++) f[i] = (stream.size() > i) ? stream[stream.size() - 1 - i] : 1'b0;
        for (int i = 0; i < 8; i++) ones += int'(f[8 + i]);
        m_ovr   = m_ovr | (m_valid & ~frame_ready);
        m_valid = ~frame_ready;
        m_pos   = f[15:8];
        m_seg   = f[7:0];
        m_perr  = ones != 1;
        m_lerr  = m_cnt != 16;
        m_idx   = 3'd0;
        if (!m_perr) for (int i = 0; i < 8; i++) if (f[8 + i]) m_idx = 3'(i);
        if (!m_perr && !m_lerr) m_disp[m_idx] = m_seg;
        m_cnt = 0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        clks(3);
        rst_n = 1'b1;
        model_reset();
    endtask
    task automatic send_bit(input bit b, input bit with_latch);
        sda = b;
        clks(H);
        sclk = 1'b1;
        if (with_latch) slatch = 1'b1;
        stream.push_back(b);
        while (stream.size() > 16) void'(stream.pop_front());
        if (m_cnt < 31) m_cnt++;
        clks(H);
        sclk = 1'b0;
        slatch = 1'b0;
        clks(H);
        if (with_latch) model_latch();
    endtask
    task automatic latch();
        slatch = 1'b1;
        clks(H);
        slatch = 1'b0;
        clks(H);
        model_latch();
    endtask
    task automatic send_frame(input logic [7:0] pos, input logic [7:0] seg, input int nbits, input bit coincide);
        logic [15:0] w;
        w = {pos, seg};
        for (int i = nbits - 1; i >= 0; i--)
            send_bit((i < 16) ? w[i] : 1'($urandom), coincide && i == 0);
        if (!coincide) latch();
    endtask
    task automatic check_all(input string tag);
        logic [63:0] e;
        for (int i = 0; i < 8; i++) e[63 - 8 * i -: 8] = m_disp[i];
        clks(2);
        chk({tag, "_valid"}, 64'(frame_valid), 64'(m_valid));
        chk({tag, "_pos"}, 64'(frame_pos), 64'(m_pos));
        chk({tag, "_seg"}, 64'(frame_seg), 64'(m_seg));
        chk({tag, "_idx"}, 64'(frame_idx), 64'(m_idx));
        chk({tag, "_perr"}, 64'(pos_err), 64'(m_perr));
        chk({tag, "_lerr"}, 64'(len_err), 64'(m_lerr));
        chk({tag, "_ovr"}, 64'(overrun), 64'(m_ovr));
        chk({tag, "_disp"}, disp, e);
    endtask
    task automatic accept();
        frame_ready = 1'b1;
        clks(1);
        frame_ready = 1'b0;
        m_valid = 1'b0;
        chk("accept_valid", 64'(frame_valid), 64'd0);
    endtask
    initial begin
        int v0;
        logic [7:0] p;
        do_reset();
        check_all("reset");
        frame_ready = 1'b1;
        v0 = vcyc;
        send_frame(8'h01, 8'hC0, 16, 1'b0);
        check_all("t1");
        chk("t1_pulse", 64'(vcyc - v0), 64'd1);
        chk("t1_disp0", disp, 64'hC0FF_FFFF_FFFF_FFFF);
        frame_ready = 1'b0;
        send_frame(8'h80, 8'hF9, 16, 1'b0);
        send_frame(8'h04, 8'hA4, 16, 1'b0);
        check_all("t2");
        chk("t2_ovr", 64'(overrun), 64'd1);
        accept();
        send_frame(8'h03, 8'h00, 16, 1'b0);
        check_all("t3");
        accept();
        send_frame(8'h20, 8'h88, 15, 1'b0);
        check_all("t4a");
        accept();
        send_frame(8'h10, 8'h92, 18, 1'b0);
        check_all("t4b");
        accept();
        for (int i = 7; i >= 0; i--) send_bit(1'($urandom), 1'b0);
        do_reset();
        check_all("t5rst");
        send_frame(8'h02, 8'hB0, 16, 1'b0);
        check_all("t5");
        chk("t5_disp", disp, 64'hFFB0_FFFF_FFFF_FFFF);
        accept();
        send_frame(8'h40, 8'h82, 16, 1'b1);
        check_all("t6");
        accept();
        for (int n = 0; n < 30; n++) begin
            p = ($urandom % 2) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            send_frame(p, 8'($urandom), ($urandom % 4 != 0) ? 16 : $urandom_range(12, 20), 1'($urandom % 3 == 0));
            check_all("rnd");
            if ($urandom % 3 != 0) accept();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/yl3_frame_receiver.md
Name: yl3_frame_receiver

Overview:
- Receive-side counterpart of the YL-3 74HC595 display driver. Deserialises the sda/sclk/slatch stream back into 16-bit frames: position byte first, then segment byte, MSB first.
- Validates each frame and maintains an 8-digit shadow of the displayed segment bytes.
- Used as an on-chip loopback checker and as the bench monitor for the display path.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on each of sda, sclk and slatch (legal range 2..4).
- FRAME_BITS, 16: expected sclk rising edges per latch.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  synchronous, active-low reset
- sda  in  1  serial data, asynchronous to clk
- sclk  in  1  serial clock, asynchronous to clk
- slatch  in  1  latch strobe, asynchronous to clk
- frame_ready  in  1  consumer accepts the held frame
- frame_valid  out  1  a frame is held and not yet accepted
- frame_pos  out  8  received position byte
- frame_seg  out  8  received segment byte (active-low .GFEDCBA)
- frame_idx  out  3  digit index from the one-hot position
- pos_err  out  1  frame_pos was not exactly one-hot
- len_err  out  1  bit count at latch was not FRAME_BITS
- overrun  out  1  sticky; a frame was lost
- disp  out  64  segment shadow; digit 0 in [63:56] through digit 7 in [7:0]

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state on that edge:
  - frame_valid, pos_err, len_err, overrun = 0
  - frame_pos, frame_seg, frame_idx = 0
  - shift register = 0, bit counter = 0
  - disp = all ones (blank)
  - synchroniser flops = 0
- Reset mid-frame discards the partial frame. The first frame accepted after reset starts at the next sclk rise.
- Synchronisation: each input passes through SYNC_STAGES flops, plus one more flop for edge detection. Edges are detected only on synchronised signals.
- Shift, on an sclk rise:
  - shift register = {sr[14:0], synchronised sda}.
  - Bit counter increments, saturating at 31.
- More than FRAME_BITS rises: the register keeps the last 16 bits, as a real 595 pair does, and len_err is flagged at latch.
- Latch, on an slatch rise (cycle N):
  - On edge N+1: frame_pos = sr[15:8], frame_seg = sr[7:0], frame_valid = 1, bit counter = 0.
  - pos_err = (popcount(frame_pos) != 1).
  - len_err = (count != FRAME_BITS).
  - frame_idx = bit position of the single set bit; 0 if pos_err.
- Simultaneous sclk rise and slatch rise in the same synchronised cycle: the shift is applied first. The latched frame includes that bit, and the count includes it.
- Shadow update: only when both pos_err=0 and len_err=0. disp byte for digit frame_idx is set to frame_seg on the same edge as frame_valid. Other bytes are unchanged.
- Handshake:
  - frame_valid stays high until a clk edge with frame_valid & frame_ready, then drops on that edge.
  - Outputs are stable while frame_valid=1 and frame_ready=0.
- Overrun:
  - A new latch while frame_valid=1 and not accepted in the same cycle sets overrun (sticky until reset).
  - The new frame overwrites the held frame.
  - The shadow still updates if the new frame is error-free.
  - A latch in the same cycle as acceptance is not an overrun; frame_valid stays 1 with the new data.
- slatch held high: only the rising edge counts. sclk rises while slatch is high still shift.
- Latency: sclk or slatch pin edge to effect is SYNC_STAGES+2 clk.
- Input limit: inputs must hold each level at least 2 clk periods. The driver's 6-clk sclk half-period satisfies this.
- State machine: IDLE (count=0) goes to SHIFT on the first sclk rise. SHIFT goes to IDLE on latch, after the frame is captured. This is a tracked 1-bit state; frame_valid is independent of it.

Test Plan:
- Drive frame 0x01_C0 (pos bit0, "0"), 16 rises then latch, frame_ready=1 -> frame_valid one cycle; frame_pos=0x01, frame_seg=0xC0, frame_idx=0; no errors; disp[63:56]=0xC0, rest 0xFF.
- Back-to-back frames 0x80_F9 then 0x04_A4 with frame_ready=0, then accept -> overrun=1; held frame 0x04/0xA4, idx=2; disp[7:0]=0xF9, disp[47:40]=0xA4.
- Position 0x03, seg 0x00 -> pos_err=1, frame_idx=0; disp unchanged.
- 15 rises then latch -> len_err=1, no shadow update. 18 rises ending ...0x10_92 then latch -> len_err=1, frame_pos=0x10, frame_seg=0x92.
- Assert rst_n=0 after 8 bits, then send a full 0x02_B0 frame -> single clean frame, idx=1, disp[55:48]=0xB0, no stale bits.
- Last sclk rise and slatch rise coincident after sync -> frame includes the 16th bit, len_err=0.
